// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC default,
// the NOP word shown to decode when nothing is valid, the fetch queue
// depth and the {pc+4, instruction} entry carried through the queue.
package instruction_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam int          FQ_DEPTH         = 2;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } fetch_entry_t;

   // Clears the byte offset so every fetch address is word aligned.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and the memory
// (slave). The memory answers an accepted request exactly one cycle later.
interface instruction_fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/instruction_fetch_fetch_queue.sv
// Two-entry FIFO holding fetched {pc+4, instruction} pairs waiting for
// decode. Supports push and pop in the same cycle (including when full)
// and a synchronous flush used on redirects.
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t push_data,
   output fetch_entry_t head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t slots [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slots[rd_ptr];

   // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; a push into a full queue reuses the slot being popped.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         slots[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues sequential word fetches, keeps at most
// two instructions buffered or in flight, hands them to decode in order,
// and restarts from a new PC on a redirect. A 1-bit epoch tags each
// request so responses belonging to a discarded path are dropped.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          QDEPTH   = FQ_DEPTH
)
(
   input  logic                       clk,
   input  logic                       rst,
   instruction_fetch_if.master        imem,
   input  logic                       redirect_en,
   input  logic [31:0]                redirect_pc,
   input  logic                       stall_D,
   output logic                       instr_valid,
   output logic [31:0]                Instruction_D,
   output logic [31:0]                PC_D
);

   logic [31:0]  pc;
   logic [31:0]  issued_addr;
   logic         in_flight;
   logic         in_flight_epoch;
   logic         epoch;
   logic         issue;
   logic         dequeue;
   logic         accept;
   logic [1:0]   q_count;
   logic         q_full;
   logic         q_empty;
   logic [2:0]   occupancy;
   fetch_entry_t q_head;
   fetch_entry_t q_push_data;

   assign occupancy   = {1'b0, q_count} + {2'b00, in_flight};
   assign dequeue     = !rst && !redirect_en && !q_empty && !stall_D;
   assign issue       = !rst && !redirect_en &&
                        ((occupancy < 3'(QDEPTH)) || dequeue);
   assign accept      = !rst && !redirect_en && imem.imem_rvalid && in_flight &&
                        (in_flight_epoch == epoch) && (!q_full || dequeue);
   assign q_push_data = '{pc4: issued_addr + 32'd4, instr: imem.imem_rdata};

   assign imem.imem_req  = issue;
   assign imem.imem_addr = rst ? align_word(RESET_PC) : pc;
   assign instr_valid    = !rst && !q_empty;
   assign Instruction_D  = instr_valid ? q_head.instr : NOP_WORD;
   assign PC_D           = instr_valid ? q_head.pc4   : NOP_WORD;

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_en),
      .push      (accept),
      .pop       (dequeue),
      .push_data (q_push_data),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   // Fetch PC, epoch and in-flight tracking; redirect retargets the PC and
   // flips the epoch so the outstanding response is recognised as stale.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc              <= align_word(RESET_PC);
         issued_addr     <= align_word(RESET_PC);
         in_flight       <= 1'b0;
         in_flight_epoch <= 1'b0;
         epoch           <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) begin
            issued_addr     <= pc;
            in_flight_epoch <= epoch;
         end
         if (redirect_en) begin
            pc    <= align_word(redirect_pc);
            epoch <= ~epoch;
         end else if (issue) begin
            pc <= pc + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a directed table for reset/stream/stall,
// hand-written redirect and reset sequences, then random traffic checked
// against a queue-based model of the fetch rules.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

   typedef struct {
      logic        r;
      logic        st;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pcd;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall_D = 1'b0;
   logic        instr_valid;
   logic [31:0] Instruction_D;
   logic [31:0] PC_D;

   instruction_fetch_if bus();

   instruction_fetch #(
      .RESET_PC (RESET_PC_TB),
      .QDEPTH   (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (bus.master),
      .redirect_en   (redirect_en),
      .redirect_pc   (redirect_pc),
      .stall_D       (stall_D),
      .instr_valid   (instr_valid),
      .Instruction_D (Instruction_D),
      .PC_D          (PC_D)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;

   logic        s_req;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_instr;
   logic [31:0] s_pcd;

   logic        mem_req = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] rdata_drv = 32'h0;
   logic [31:0] scramble = 32'h0;

   logic [31:0] m_next = RESET_PC_TB;
   logic        m_pending = 1'b0;
   logic [31:0] m_pending_addr = 32'h0;
   ent_t        m_ready[$];

   vec_t        vecs [15];

   // Compares one observed value against the bench's expectation.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one clock cycle: drives inputs, checks outputs against the model,
   // advances the model and plays the one-cycle-latency memory.
   task automatic applyStimulus(input logic r, input logic red, input logic [31:0] rpc,
                                input logic st, input logic inject);
      logic        e_req;
      logic        e_valid;
      logic        deq;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pcd;
      rst         = r;
      redirect_en = red;
      redirect_pc = rpc;
      stall_D     = st;
      if (inject) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = 32'hDEAD_BEEF;
         rdata_drv       = 32'hDEAD_BEEF;
      end
      e_valid = 1'b0;
      e_instr = 32'h0;
      e_pcd   = 32'h0;
      deq     = 1'b0;
      e_req   = 1'b0;
      e_addr  = RESET_PC_TB;
      if (!r) begin
         if (m_ready.size() != 0) begin
            e_valid = 1'b1;
            e_instr = m_ready[0].word;
            e_pcd   = m_ready[0].addr + 32'd4;
         end
         deq    = e_valid && !st && !red;
         e_req  = !red && (((m_ready.size() + int'(m_pending)) < 2) || deq);
         e_addr = m_next;
      end
      #2;
      s_req   = bus.imem_req;
      s_addr  = bus.imem_addr;
      s_valid = instr_valid;
      s_instr = Instruction_D;
      s_pcd   = PC_D;
      checkOutput("imem_req", {31'h0, s_req}, {31'h0, e_req});
      checkOutput("imem_addr", s_addr, e_addr);
      checkOutput("instr_valid", {31'h0, s_valid}, {31'h0, e_valid});
      checkOutput("Instruction_D", s_instr, e_instr);
      checkOutput("PC_D", s_pcd, e_pcd);
      mem_req  = bus.imem_req;
      mem_addr = bus.imem_addr;
      if (r) begin
         m_next    = RESET_PC_TB;
         m_pending = 1'b0;
         m_ready.delete();
      end else if (red) begin
         m_ready.delete();
         m_pending = 1'b0;
         m_next    = rpc & 32'hFFFF_FFFC;
      end else begin
         if (deq) begin
            void'(m_ready.pop_front());
         end
         if (m_pending) begin
            m_ready.push_back('{addr: m_pending_addr, word: rdata_drv});
         end
         m_pending = e_req;
         if (e_req) begin
            m_pending_addr = m_next;
            m_next         = m_next + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      rdata_drv       = mem_addr ^ scramble;
      bus.imem_rvalid = mem_req;
      bus.imem_rdata  = rdata_drv;
   endtask

   // Directed, hand-written and random phases, then the summary line.
   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 32'h00};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 32'h04};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h08};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h0C};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h0C};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h0C};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h0C};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08, 32'h0C};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 32'h0C};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h10};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h14};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h14, 32'h18};

      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].r, 1'b0, 32'h0, vecs[i].st, 1'b0);
         checkOutput("tbl_req", {31'h0, s_req}, {31'h0, vecs[i].e_req});
         checkOutput("tbl_addr", s_addr, vecs[i].e_addr);
         checkOutput("tbl_valid", {31'h0, s_valid}, {31'h0, vecs[i].e_valid});
         checkOutput("tbl_instr", s_instr, vecs[i].e_instr);
         checkOutput("tbl_pcd", s_pcd, vecs[i].e_pcd);
      end

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
      checkOutput("redir_req_off", {31'h0, s_req}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("redir_addr", s_addr, 32'h0000_0100);
      checkOutput("redir_valid1", {31'h0, s_valid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("redir_valid2", {31'h0, s_valid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("redir_first_pcd", s_pcd, 32'h0000_0104);
      checkOutput("redir_first_instr", s_instr, 32'h0000_0100);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("full_req_off", {31'h0, s_req}, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("redir_deq_valid", {31'h0, s_valid}, 32'h0);
      checkOutput("redir_deq_addr", s_addr, 32'h0000_2000);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("redir_deq_pcd", s_pcd, 32'h0000_2004);

      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("wrap_addr0", s_addr, 32'hFFFF_FFF8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("wrap_addr1", s_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("wrap_addr2", s_addr, 32'h0000_0000);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("wrap_pcd_fc", s_pcd, 32'h0000_0000);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("wrap_pcd_last", s_pcd, 32'h0000_0004);

      applyStimulus(1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b0);
      checkOutput("rst_valid", {31'h0, s_valid}, 32'h0);
      checkOutput("rst_addr", s_addr, RESET_PC_TB);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("post_rst_addr", s_addr, RESET_PC_TB);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("stale_dropped", {31'h0, s_valid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("restart_instr", s_instr, RESET_PC_TB);
      checkOutput("restart_pcd", s_pcd, RESET_PC_TB + 32'd4);

      scramble = 32'h5A5A_A5A5;
      for (int i = 0; i < 600; i++) begin
         logic        r;
         logic        red;
         logic        st;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 63) == 0);
         red = !r && ($urandom_range(0, 9) == 0);
         st  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) begin
            rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         end else begin
            rpc = $urandom;
         end
         applyStimulus(r, red, rpc, st, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
